// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock, then
// releases the downstream system reset. Lock losses in RUN are counted and
// flagged. Repeated lock timeouts park the block in FAULT until software
// asks for another attempt.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       req_relock,
  input  logic       clear_status,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [2:0] state,
  output logic       fault,
  output logic       lock_lost,
  output logic [7:0] relock_count
);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Terminal counter values: the counter reads 0 on the first cycle of a
  // state, so the last cycle of an N-cycle dwell sees N-1.
  localparam logic [23:0] RST_LAST     = 24'(RST_PULSE_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [23:0] STABLE_LAST  = 24'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t      state_q;
  state_t      state_nxt;
  logic [23:0] cnt_q;
  logic [23:0] cnt_nxt;
  logic [3:0]  retry_q;
  logic [3:0]  retry_nxt;
  logic        sync_p0;
  logic        sync_p1;
  logic        locked_s;
  logic        loss_evt;

  // Saturating increment for the lock-loss counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pll_locked;
      sync_p1 <= sync_p0;
    end
  end

  assign locked_s = sync_p1;

  // Next-state, retry bookkeeping and loss detection.
  always_comb begin
    state_nxt = state_q;
    retry_nxt = retry_q;
    loss_evt  = 1'b0;
    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q >= RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_STABLE;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          retry_nxt = retry_q + 4'd1;
          state_nxt = (retry_q + 4'd1 == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
        end
      end
      ST_STABLE: begin
        // A single unlocked cycle sends us back to wait with a fresh timeout;
        // it does not count as a failed attempt.
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt_q >= STABLE_LAST) begin
          state_nxt = ST_RUN;
          retry_nxt = 4'd0;
        end
      end
      ST_RUN: begin
        // Loss of lock takes priority; a coincident relock request merges
        // into the same PLL reset entry.
        if (!locked_s) begin
          loss_evt  = 1'b1;
          state_nxt = ST_RESET_PLL;
          retry_nxt = 4'd0;
        end else if (req_relock) begin
          state_nxt = ST_RESET_PLL;
          retry_nxt = 4'd0;
        end
      end
      ST_FAULT: begin
        if (req_relock) begin
          state_nxt = ST_RESET_PLL;
          retry_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = ST_RESET_PLL;
        retry_nxt = 4'd0;
      end
    endcase
  end

  // Dwell counter: cleared on every state entry, advanced only in timed states.
  always_comb begin
    cnt_nxt = cnt_q;
    if (state_nxt != state_q) begin
      cnt_nxt = 24'd0;
    end else if ((state_q == ST_RESET_PLL) || (state_q == ST_WAIT_LOCK) ||
                 (state_q == ST_STABLE)) begin
      cnt_nxt = cnt_q + 24'd1;
    end
  end

  // State, counter and retry registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET_PLL;
      cnt_q   <= 24'd0;
      retry_q <= 4'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      retry_q <= retry_nxt;
    end
  end

  // Reset and fault outputs decoded from the next state so they switch on
  // the same edge as the state register and never glitch.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pll_rst   <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAULT);
      sys_rst_n <= (state_nxt == ST_RUN);
      fault     <= (state_nxt == ST_FAULT);
    end
  end

  // Sticky loss flag and saturating loss counter; a loss beats a clear.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_lost    <= 1'b0;
      relock_count <= 8'd0;
    end else if (loss_evt) begin
      lock_lost    <= 1'b1;
      relock_count <= clear_status ? 8'd1 : sat_inc8(relock_count);
    end else if (clear_status) begin
      lock_lost    <= 1'b0;
      relock_count <= 8'd0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus randomized traffic,
// all compared each cycle against a behavioural model of the lock sequence.
module tb_pll_lock_supervisor;

  localparam int RPC = 4;
  localparam int TMO = 32;
  localparam int STB = 8;
  localparam int MR  = 2;

  localparam int SEL_STATE = 0;
  localparam int SEL_PRST  = 1;
  localparam int SEL_FAULT = 2;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       req_relock;
  logic       clear_status;
  logic       pll_rst;
  logic       sys_rst_n;
  logic [2:0] state;
  logic       fault;
  logic       lock_lost;
  logic [7:0] relock_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit lk_cur  = 1'b0;

  // Model state: phase uses the published state numbering.
  int m_ph;
  int m_dwell;
  int m_tries;
  int m_cnt;
  bit m_lost;
  bit h_new;
  bit h_old;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (RPC),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES (STB),
    .MAX_RETRIES        (MR)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .req_relock  (req_relock),
    .clear_status(clear_status),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .state       (state),
    .fault       (fault),
    .lock_lost   (lock_lost),
    .relock_count(relock_count)
  );

  always #5 refclk = ~refclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_dwell = 0; m_tries = 0; m_cnt = 0; m_lost = 0;
    h_new = 0; h_old = 0;
  endtask

  task automatic model_go(input int ph);
    m_ph    = ph;
    m_dwell = 0;
  endtask

  // One refclk edge of the lock sequence; the FSM sees pll_locked as it was
  // two edges ago.
  task automatic model_step(input bit lk, input bit rr, input bit cs);
    bit ls;
    bit lose;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls    = h_old;
    h_old = h_new;
    h_new = lk;
    lose  = 0;
    m_dwell++;
    case (m_ph)
      0: if (m_dwell == RPC) model_go(1);
      1: begin
        if (ls) model_go(2);
        else if (m_dwell == TMO) begin
          m_tries++;
          model_go((m_tries == MR) ? 4 : 0);
        end
      end
      2: begin
        if (!ls) model_go(1);
        else if (m_dwell == STB) begin
          m_tries = 0;
          model_go(3);
        end
      end
      3: begin
        if (!ls) begin lose = 1; model_go(0); end
        else if (rr) model_go(0);
      end
      default: if (rr) begin m_tries = 0; model_go(0); end
    endcase
    if (lose) begin
      m_lost = 1;
      m_cnt  = cs ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (cs) begin
      m_lost = 0;
      m_cnt  = 0;
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [2:0] ph;
    logic [7:0] c;
    ph = 3'(m_ph);
    c  = 8'(m_cnt);
    return {17'd0, ph, logic'(m_ph == 0 || m_ph == 4), logic'(m_ph == 3),
            logic'(m_ph == 4), logic'(m_lost), c};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {17'd0, state, pll_rst, sys_rst_n, fault, lock_lost, relock_count};
  endfunction

  function automatic int sig(input int sel);
    case (sel)
      SEL_STATE: return int'(state);
      SEL_PRST:  return int'(pll_rst);
      default:   return int'(fault);
    endcase
  endfunction

  // Apply inputs for one edge, advance the model, compare at the falling edge.
  task automatic cycle(input bit lk, input bit rr, input bit cs);
    pll_locked   = lk;
    req_relock   = rr;
    clear_status = cs;
    @(posedge refclk);
    model_step(lk, rr, cs);
    @(negedge refclk);
    chk("cyc", dut_vec(), model_vec());
  endtask

  task automatic wait_sig(input string tag, input int sel, input int val,
                          input int bound, output int k);
    k = 0;
    do begin
      cycle(lk_cur, 1'b0, 1'b0);
      k++;
    end while (sig(sel) != val && k < bound);
    chk({tag, "_reach"}, sig(sel), val);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_sys_rst_n"}, sys_rst_n, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_lock_lost"}, lock_lost, 0);
    chk({tag, "_relock_count"}, relock_count, 0);
  endtask

  initial begin
    int k;
    int rises;
    int hi2;
    int first_low;
    int rate;
    bit prev;
    bit seen1;
    logic [11:0] seq;
    logic [2:0] last;

    rst_n = 1'b1; pll_locked = 1'b0; req_relock = 1'b0; clear_status = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("por");
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Nominal lock
    lk_cur = 0;
    wait_sig("nom_prst", SEL_PRST, 0, 20, k);
    chk("nom_prst_len", k, RPC);
    repeat (9) cycle(1'b0, 1'b0, 1'b0);
    lk_cur = 1;
    seq = {9'd0, state};
    last = state;
    k = 0;
    do begin
      cycle(1'b1, 1'b0, 1'b0);
      k++;
      if (state != last) seq = {seq[7:0], 1'b0, state};
      last = state;
    end while (sys_rst_n !== 1'b1 && k < 40);
    // two synchronizer edges, one edge into STABLE, eight locked STABLE edges
    chk("nom_lock_lat", k, 11);
    chk("nom_state_seq", seq, 12'h123);
    chk("nom_run", state, 3);

    // Loss in RUN
    lk_cur = 0;
    wait_sig("loss", SEL_STATE, 0, 20, k);
    chk("loss_lat", k, 3);
    chk("loss_sys_rst_n", sys_rst_n, 0);
    chk("loss_flag", lock_lost, 1);
    chk("loss_cnt", relock_count, 1);
    lk_cur = 1;
    wait_sig("relock1", SEL_STATE, 3, 40, k);

    // Loss and relock request on the same edge
    lk_cur = 0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("simul_rr_state", state, 0);
    chk("simul_rr_cnt", relock_count, 2);
    wait_sig("simul_rr_prst", SEL_PRST, 0, 20, k);
    chk("simul_rr_prst_len", k, RPC);
    lk_cur = 1;
    wait_sig("relock2", SEL_STATE, 3, 40, k);

    // Loss and clear on the same edge
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("simul_clr_flag", lock_lost, 1);
    chk("simul_clr_cnt", relock_count, 1);
    lk_cur = 1;
    wait_sig("relock3", SEL_STATE, 3, 40, k);

    // Clear alone, relock request in RUN, relock request ignored in RESET_PLL
    cycle(1'b1, 1'b0, 1'b1);
    chk("clr_flag", lock_lost, 0);
    chk("clr_cnt", relock_count, 0);
    chk("clr_state", state, 3);
    cycle(1'b1, 1'b1, 1'b0);
    chk("rr_run_state", state, 0);
    chk("rr_run_flag", lock_lost, 0);
    cycle(1'b1, 1'b1, 1'b0);
    wait_sig("rr_ign", SEL_PRST, 0, 20, k);
    chk("rr_ign_len", k, RPC - 1);
    wait_sig("relock4", SEL_STATE, 3, 40, k);

    // Saturation of the loss counter
    for (int i = 0; i < 256; i++) begin
      lk_cur = 0;
      wait_sig("sat_loss", SEL_STATE, 0, 10, k);
      if (i == 254) chk("sat_255th", relock_count, 255);
      lk_cur = 1;
      wait_sig("sat_lock", SEL_STATE, 3, 40, k);
    end
    chk("sat_cnt", relock_count, 255);
    chk("sat_flag", lock_lost, 1);

    // Asynchronous reset in the middle of WAIT_LOCK
    lk_cur = 0;
    wait_sig("ar_loss", SEL_STATE, 0, 10, k);
    wait_sig("ar_wait", SEL_STATE, 1, 10, k);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_reset_outs("async");
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Lock never arrives: pulse, wait, pulse, wait, fault
    k = 0; rises = 0; hi2 = 0; first_low = 0; prev = 1'b1;
    do begin
      cycle(1'b0, 1'b0, 1'b0);
      k++;
      if (pll_rst === 1'b0 && first_low == 0) first_low = k;
      if (pll_rst && !prev) rises++;
      if (rises > 0 && pll_rst && !fault) hi2++;
      prev = pll_rst;
    end while (fault !== 1'b1 && k < 200);
    chk("ar_prst_len", first_low, RPC);
    chk("to_fault_lat", k, 2 * (RPC + TMO));
    chk("to_fault_rises", rises, 2);
    chk("to_fault_pulse2", hi2, RPC);
    chk("flt_state", state, 4);
    chk("flt_pll_rst", pll_rst, 1);
    chk("flt_sys_rst_n", sys_rst_n, 0);

    // Lock arriving in FAULT is ignored; relock request leaves it
    lk_cur = 1;
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    chk("flt_hold", state, 4);
    cycle(1'b1, 1'b1, 1'b0);
    chk("flt_exit_state", state, 0);
    chk("flt_exit_fault", fault, 0);
    wait_sig("flt_prst", SEL_PRST, 0, 20, k);
    chk("flt_prst_len", k, RPC);
    wait_sig("relock5", SEL_STATE, 3, 40, k);

    // Glitch in STABLE during the second attempt keeps the retry count
    lk_cur = 0;
    wait_sig("gl_loss", SEL_STATE, 0, 10, k);
    wait_sig("gl_wait1", SEL_STATE, 1, 10, k);
    wait_sig("gl_retry1", SEL_STATE, 0, 40, k);
    wait_sig("gl_wait2", SEL_STATE, 1, 10, k);
    lk_cur = 1;
    wait_sig("gl_stable", SEL_STATE, 2, 10, k);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    lk_cur = 0;
    wait_sig("gl_back", SEL_STATE, 1, 10, k);
    chk("gl_back_lat", k, 2);
    wait_sig("gl_fault", SEL_STATE, 4, 40, k);
    chk("gl_fault_lat", k, TMO);

    // Glitch in STABLE followed by a clean lock
    cycle(1'b0, 1'b1, 1'b0);
    wait_sig("gr_wait", SEL_STATE, 1, 10, k);
    lk_cur = 1;
    wait_sig("gr_stable", SEL_STATE, 2, 10, k);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    k = 0; seen1 = 0;
    do begin
      cycle(1'b1, 1'b0, 1'b0);
      k++;
      if (state == 3'd1) seen1 = 1;
    end while (state != 3'd3 && k < 40);
    chk("gr_seen_wait", seen1, 1);
    chk("gr_run_lat", k, 11);

    // Randomized traffic
    rate = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rate = $urandom_range(4, 100);
      if ($urandom_range(1, rate) == 1) lk_cur = !lk_cur;
      if ($urandom_range(0, 399) == 0) begin
        #3 rst_n = 1'b0;
        model_reset();
        cycle(lk_cur, 1'b0, 1'b0);
        rst_n = 1'b1;
      end else begin
        cycle(lk_cur, ($urandom_range(0, 39) == 0), ($urandom_range(0, 49) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
